// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: N_MASTERS masters share one slave port.
//
// Handshake: master i requests while m_cyc[i] & m_stb[i] are high and must
// hold the request (and its address/data) until it sees m_ack[i] or m_rty[i].
// A transfer completes on the rising edge where s_ack is high while BUSY.
// m_rty[grant] marks a slave timeout. Dropping the request while BUSY abandons
// the transfer without ACK or RTY.
module wb_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 128,
    parameter int TIMEOUT   = 64,
    localparam int SEL_W    = DATA_W / 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_MASTERS-1:0]          m_cyc,
    input  logic [N_MASTERS-1:0]          m_stb,
    input  logic [N_MASTERS-1:0]          m_we,
    input  logic [N_MASTERS*SEL_W-1:0]    m_sel,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_adr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_dat_w,
    output logic [DATA_W-1:0]             m_dat_r,
    output logic [N_MASTERS-1:0]          m_ack,
    output logic [N_MASTERS-1:0]          m_rty,
    output logic                          s_cyc,
    output logic                          s_stb,
    output logic                          s_we,
    output logic [SEL_W-1:0]              s_sel,
    output logic [ADDR_W-1:0]             s_adr,
    output logic [DATA_W-1:0]             s_dat_w,
    input  logic [DATA_W-1:0]             s_dat_r,
    input  logic                          s_ack,
    output logic                          dbg_state
);

    localparam int GNT_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [GNT_W:0] N_WIDE = (GNT_W + 1)'(N_MASTERS);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [GNT_W-1:0]     grant_q, last_grant_q, pick;
    logic                 pick_valid;
    logic [CNT_W-1:0]     wait_q;
    logic [N_MASTERS-1:0] req;
    logic                 gnt_req;
    logic                 timeout_hit;

    assign req         = m_cyc & m_stb;
    assign gnt_req     = req[grant_q];
    assign timeout_hit = (TIMEOUT != 0) && (wait_q == CNT_W'(TIMEOUT - 1));
    assign m_dat_r     = s_dat_r;
    assign dbg_state   = (state_q == BUSY);

    // Round-robin pick: first requester after last_grant, wrapping around.
    always_comb begin
        logic [GNT_W:0] cand;
        pick_valid = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            cand = {1'b0, last_grant_q} + (GNT_W + 1)'(k);
            if (cand >= N_WIDE) cand = cand - N_WIDE;
            if (!pick_valid && req[cand[GNT_W-1:0]]) begin
                pick_valid = 1'b1;
                pick       = cand[GNT_W-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: grant from IDLE; leave BUSY on ack, abort or timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = BUSY;
            BUSY:    if (s_ack || !gnt_req || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant, round-robin pointer and ACK wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q      <= '0;
            last_grant_q <= GNT_W'(N_MASTERS - 1);
            wait_q       <= '0;
        end else if (state_q == IDLE) begin
            if (pick_valid) begin
                grant_q <= pick;
                wait_q  <= '0;
            end
        end else begin
            // An abort (request dropped, no ack) leaves the pointer alone.
            if (s_ack || (gnt_req && timeout_hit)) last_grant_q <= grant_q;
            if (!s_ack && (wait_q != CNT_W'(TIMEOUT))) wait_q <= wait_q + 1'b1;
        end
    end

    // Outputs: slave port mirrors the granted master only while BUSY.
    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_sel   = '0;
        s_adr   = '0;
        s_dat_w = '0;
        m_ack   = '0;
        m_rty   = '0;
        if (state_q == BUSY) begin
            s_cyc          = m_cyc[grant_q];
            s_stb          = m_stb[grant_q];
            s_we           = m_we[grant_q];
            s_sel          = m_sel[grant_q * SEL_W +: SEL_W];
            s_adr          = m_adr[grant_q * ADDR_W +: ADDR_W];
            s_dat_w        = m_dat_w[grant_q * DATA_W +: DATA_W];
            m_ack[grant_q] = s_ack;
            m_rty[grant_q] = !s_ack && gnt_req && timeout_hit;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter with three masters and a short slave timeout.
module tb_wb_arbiter;

    localparam int N      = 3;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 128;
    localparam int SEL_W  = DATA_W / 8;
    localparam int TMO    = 4;

    logic                 clk;
    logic                 rst_n;
    logic [N-1:0]         m_cyc, m_stb, m_we;
    logic [N*SEL_W-1:0]   m_sel;
    logic [N*ADDR_W-1:0]  m_adr;
    logic [N*DATA_W-1:0]  m_dat_w;
    logic [DATA_W-1:0]    m_dat_r;
    logic [N-1:0]         m_ack, m_rty;
    logic                 s_cyc, s_stb, s_we;
    logic [SEL_W-1:0]     s_sel;
    logic [ADDR_W-1:0]    s_adr;
    logic [DATA_W-1:0]    s_dat_w;
    logic [DATA_W-1:0]    s_dat_r;
    logic                 s_ack;
    logic                 dbg_state;

    wb_arbiter #(.N_MASTERS(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel),
        .m_adr(m_adr), .m_dat_w(m_dat_w), .m_dat_r(m_dat_r),
        .m_ack(m_ack), .m_rty(m_rty),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack),
        .dbg_state(dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: per-master request state and a priority list whose
    // head is the next master to be served when requesting.
    int                 rr_q[$];
    logic               pend [N];
    logic [ADDR_W-1:0]  a_adr[N];
    logic               a_we [N];
    logic [SEL_W-1:0]   a_sel[N];
    logic [DATA_W-1:0]  a_dat[N];

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic drive_bus();
        for (int i = 0; i < N; i++) begin
            m_cyc[i] = pend[i];
            m_stb[i] = pend[i];
            m_we[i]  = a_we[i];
            m_sel[i*SEL_W +: SEL_W]    = a_sel[i];
            m_adr[i*ADDR_W +: ADDR_W]  = a_adr[i];
            m_dat_w[i*DATA_W +: DATA_W] = a_dat[i];
        end
    endtask

    task automatic raise(input int i, input logic [ADDR_W-1:0] adr, input logic we,
                         input logic [SEL_W-1:0] sel, input logic [DATA_W-1:0] dat);
        a_adr[i] = adr; a_we[i] = we; a_sel[i] = sel; a_dat[i] = dat;
        pend[i] = 1'b1;
        drive_bus();
    endtask

    task automatic raise_rand(input int i);
        raise(i, ADDR_W'($urandom()), 1'($urandom_range(0, 1)),
              SEL_W'($urandom()), rand_data());
    endtask

    function automatic int model_pick();
        foreach (rr_q[k]) if (pend[rr_q[k]]) return rr_q[k];
        return -1;
    endfunction

    // After serving x, the search continues from x+1: rotate x to the tail.
    task automatic model_served(input int x);
        int t;
        while (rr_q[$] != x) begin
            t = rr_q.pop_front();
            rr_q.push_back(t);
        end
    endtask

    task automatic model_reset();
        rr_q = {};
        for (int i = 0; i < N; i++) rr_q.push_back(i);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_state"}, DATA_W'(dbg_state), '0);
        check({tag, "_cyc"},   DATA_W'(s_cyc),     '0);
        check({tag, "_stb"},   DATA_W'(s_stb),     '0);
        check({tag, "_we"},    DATA_W'(s_we),      '0);
        check({tag, "_adr"},   DATA_W'(s_adr),     '0);
        check({tag, "_sel"},   DATA_W'(s_sel),     '0);
        check({tag, "_datw"},  s_dat_w,            '0);
        check({tag, "_ack"},   DATA_W'(m_ack),     '0);
        check({tag, "_rty"},   DATA_W'(m_rty),     '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_ack = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drive_bus();
        model_reset();
        repeat (2) @(negedge clk);
        #1 check_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One granted transfer from the IDLE cycle before the grant to the IDLE
    // cycle after it. The slave acks in BUSY cycle d+1 (never if d+1 > TMO).
    task automatic run_round(input int d, output int m);
        logic [N-1:0] e_ack, e_rty;
        bit done;
        int c;
        m = model_pick();
        #1;
        check("idle_state", DATA_W'(dbg_state), '0);
        check("idle_cyc",   DATA_W'(s_cyc),     '0);
        check("idle_ack",   DATA_W'(m_ack),     '0);
        @(posedge clk); @(negedge clk);
        c = 1;
        done = 0;
        while (!done) begin
            s_ack   = (c == d + 1);
            s_dat_r = rand_data();
            #1;
            e_ack = '0; e_rty = '0;
            if (s_ack) e_ack[m] = 1'b1;
            else if (c == TMO) e_rty[m] = 1'b1;
            check("busy_state", DATA_W'(dbg_state), DATA_W'(1'b1));
            check("s_cyc",   DATA_W'(s_cyc), DATA_W'(1'b1));
            check("s_stb",   DATA_W'(s_stb), DATA_W'(1'b1));
            check("s_we",    DATA_W'(s_we),  DATA_W'(a_we[m]));
            check("s_sel",   DATA_W'(s_sel), DATA_W'(a_sel[m]));
            check("s_adr",   DATA_W'(s_adr), DATA_W'(a_adr[m]));
            check("s_dat_w", s_dat_w, a_dat[m]);
            check("m_dat_r", m_dat_r, s_dat_r);
            check("m_ack",   DATA_W'(m_ack), DATA_W'(e_ack));
            check("m_rty",   DATA_W'(m_rty), DATA_W'(e_rty));
            done = s_ack || (c == TMO);
            @(posedge clk); @(negedge clk);
            s_ack = 1'b0;
            c++;
        end
        pend[m] = 1'b0;
        model_served(m);
        drive_bus();
    endtask

    initial begin
        int m;
        rst_n = 1'b0; s_ack = 1'b0; s_dat_r = '0;
        m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat_w = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; a_adr[i] = '0; a_we[i] = 0; a_sel[i] = '0; a_dat[i] = '0;
        end

        // Single master read, slave acks two cycles after s_stb
        do_reset();
        raise(1, 12'h0A3, 1'b0, '1, '0);
        run_round(2, m);

        // Write from master 0
        raise(0, 12'h155, 1'b1, 16'h00F0, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);
        run_round(0, m);

        // Contention: masters 0 and 1 keep requesting, expected order 0,1,0,1
        do_reset();
        raise(0, 12'h100, 1'b0, '1, rand_data());
        raise(1, 12'h200, 1'b0, '1, rand_data());
        for (int r = 0; r < 4; r++) begin
            run_round(1, m);
            raise(m, 12'h100 * ADDR_W'(m + 1) + ADDR_W'(r), 1'b0, '1, rand_data());
        end

        // Timeout on master 0, then master 1 is served
        do_reset();
        raise_rand(0);
        raise_rand(1);
        run_round(99, m);
        run_round(0, m);
        // Ack coincident with the timeout cycle
        raise_rand(0);
        run_round(TMO - 1, m);

        // Abort: master 2 drops its request in BUSY; pointer must not move
        raise_rand(2);
        #1 check("abort_idle", DATA_W'(dbg_state), '0);
        @(posedge clk); @(negedge clk);
        #1 check("abort_stb", DATA_W'(s_stb), DATA_W'(1'b1));
        pend[2] = 1'b0;
        drive_bus();
        #1;
        check("abort_cyc", DATA_W'(s_cyc), '0);
        check("abort_ack", DATA_W'(m_ack), '0);
        check("abort_rty", DATA_W'(m_rty), '0);
        @(posedge clk); @(negedge clk);
        #1 check("abort_back_idle", DATA_W'(dbg_state), '0);
        raise_rand(0);
        raise_rand(1);
        run_round(0, m);

        // Reset while BUSY (master 2 granted), late ack ignored
        raise_rand(2);
        @(posedge clk); @(negedge clk);
        #1 check("pre_rst_busy", DATA_W'(dbg_state), DATA_W'(1'b1));
        rst_n = 1'b0;
        #1 check_quiet("midrst");
        s_ack = 1'b1;
        #1 check("midrst_late_ack", DATA_W'(m_ack), '0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1 check("post_rst_ack", DATA_W'(m_ack), '0);
        s_ack = 1'b0;
        run_round(0, m);

        // Randomized traffic
        for (int r = 0; r < 40; r++) begin
            bit any;
            any = 0;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) raise_rand(i);
                if (pend[i]) any = 1;
            end
            if (!any) raise_rand($urandom_range(0, N - 1));
            run_round($urandom_range(0, 6), m);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
